// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch unit: program counter, redirect and ROM addressing
//
// Purpose: sequences instruction fetch from a 1-cycle-latency ROM. The ROM
// address is the next-pc computed combinationally, so the word the ROM returns
// in the following cycle is always the instruction at the (then current) pc.
// Redirects therefore cost no bubbles.
//
// Ports:
//   clk             in   sole clock, rising edge
//   reset           in   asynchronous, active-high
//   start           in   begin execution at address 0 (from IDLE or HALTED)
//   stall           in   downstream hold request (RUN only)
//   halt            in   stop at current pc, enter HALTED
//   branch, jump    in   redirect controls from decode
//   relative        in   target is pc + destBranchJump instead of absolute
//   destBranchJump  in   absolute target or two's-complement offset
//   branchCondition in   stored compare result qualifying branch
//   romData         in   ROM read data, one cycle after romAddress
//   romAddress      out  ROM read address (combinational)
//   instruction     out  romData passed through to decode
//   insnValid       out  instruction is live
//   programCounter  out  address of the current instruction
//   halted          out  HALTED state indicator
//   retireCount     out  16-bit retired-instruction count, present only
//                        when FETCH_RETIRE_COUNT_EN is defined

package fetch_defs_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int INSN_WIDTH = 16;
endpackage

module instruction_fetch
  import fetch_defs_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stall,
  input  logic                  halt,
  input  logic                  branch,
  input  logic                  jump,
  input  logic                  relative,
  input  logic [DATA_WIDTH-1:0] destBranchJump,
  input  logic                  branchCondition,
  input  logic [INSN_WIDTH-1:0] romData,
  output logic [DATA_WIDTH-1:0] romAddress,
  output logic [INSN_WIDTH-1:0] instruction,
  output logic                  insnValid,
  output logic [DATA_WIDTH-1:0] programCounter,
  output logic                  halted
`ifdef FETCH_RETIRE_COUNT_EN
  ,
  output logic [15:0]           retireCount
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] pc;
  logic                  halted_q;
  logic [DATA_WIDTH-1:0] target;
  logic [DATA_WIDTH-1:0] next_pc;
  logic                  run;

  assign run = (state == RUN);

  // Relative targets and increments wrap naturally in DATA_WIDTH bits.
  assign target = relative ? (pc + destBranchJump) : destBranchJump;

  // Priority: stall, halt, jump, taken branch, sequential.
  always_comb begin
    next_pc = pc + 1'b1;
    if (stall || halt)
      next_pc = pc;
    else if (jump)
      next_pc = target;
    else if (branch && branchCondition)
      next_pc = target;
  end

  // Outside RUN the ROM is parked on address 0 so that the first word is
  // already available on the cycle execution (re)starts at pc 0.
  assign romAddress     = run ? next_pc : '0;
  assign insnValid      = run && !stall;
  assign instruction    = romData;
  assign programCounter = pc;
  assign halted         = halted_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= '0;
      halted_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            pc    <= '0;
          end
        end
        RUN: begin
          pc <= next_pc;
          if (!stall && halt) begin
            state    <= HALTED;
            halted_q <= 1'b1;
          end
        end
        HALTED: begin
          if (start) begin
            state    <= RUN;
            pc       <= '0;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          pc       <= '0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_RETIRE_COUNT_EN
  // Counts live, non-halt instructions; cleared whenever execution restarts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retireCount <= '0;
    end else if (!run && start) begin
      retireCount <= '0;
    end else if (run && !stall && !halt && (retireCount != 16'hFFFF)) begin
      retireCount <= retireCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch
module tb_instruction_fetch;

  localparam int DW = 8;
  localparam int IW = 16;
  localparam int S_IDLE = 0, S_RUN = 1, S_HALTED = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0, stall = 1'b0, halt = 1'b0;
  logic          branch = 1'b0, jump = 1'b0, relative = 1'b0;
  logic [DW-1:0] destBranchJump = '0;
  logic          branchCondition = 1'b0;
  logic [IW-1:0] romData = '0;
  logic [DW-1:0] romAddress;
  logic [IW-1:0] instruction;
  logic          insnValid;
  logic [DW-1:0] programCounter;
  logic          halted;
`ifdef FETCH_RETIRE_COUNT_EN
  logic [15:0]   retireCount;
`endif

  always #5 clk = ~clk;

  logic [IW-1:0] rom [256];
  always @(posedge clk) romData <= rom[romAddress];

  instruction_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .stall          (stall),
    .halt           (halt),
    .branch         (branch),
    .jump           (jump),
    .relative       (relative),
    .destBranchJump (destBranchJump),
    .branchCondition(branchCondition),
    .romData        (romData),
    .romAddress     (romAddress),
    .instruction    (instruction),
    .insnValid      (insnValid),
    .programCounter (programCounter),
    .halted         (halted)
`ifdef FETCH_RETIRE_COUNT_EN
    ,
    .retireCount    (retireCount)
`endif
  );

  typedef struct {
    int addr;
    int valid;
    int pc;
    int hlt;
    int insn;
    int chk_insn;
    int retire;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: architectural state only.
  int m_state = S_IDLE;
  int m_pc = 0;
  int m_retire = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input bit rst, input bit st, input bit sl, input bit h,
                      input bit b, input bit j, input bit r,
                      input int d, input bit c);
    exp_t e;
    int   tgt, nxt;
    @(negedge clk);
    reset = rst; start = st; stall = sl; halt = h; branch = b; jump = j;
    relative = r; destBranchJump = 8'(d); branchCondition = c;
    #1;
    if (rst) begin
      m_state = S_IDLE; m_pc = 0; m_retire = 0;
      e = '{addr: 0, valid: 0, pc: 0, hlt: 0, insn: 0, chk_insn: 0, retire: 0};
      exp_q.push_back(e);
      return;
    end
    tgt = r ? (m_pc + d) % 256 : d;
    if (sl || h)           nxt = m_pc;
    else if (j)            nxt = tgt;
    else if (b && c)       nxt = tgt;
    else                   nxt = (m_pc + 1) % 256;
    e.addr     = (m_state == S_RUN) ? nxt : 0;
    e.valid    = (m_state == S_RUN && !sl) ? 1 : 0;
    e.pc       = m_pc;
    e.hlt      = (m_state == S_HALTED) ? 1 : 0;
    e.insn     = int'(rom[m_pc]);
    e.chk_insn = e.valid;
    e.retire   = m_retire;
    exp_q.push_back(e);
    if (m_state == S_RUN) begin
      if (!sl && !h && m_retire < 65535) m_retire++;
      m_pc = nxt;
      if (!sl && h) m_state = S_HALTED;
    end else if (st) begin
      m_state = S_RUN; m_pc = 0; m_retire = 0;
    end
  endtask

  // Monitor: compares DUT outputs against queued expectations late in each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("romAddress", int'(romAddress), e.addr);
        chk("insnValid", int'(insnValid), e.valid);
        chk("programCounter", int'(programCounter), e.pc);
        chk("halted", int'(halted), e.hlt);
        if (e.chk_insn != 0) chk("instruction", int'(instruction), e.insn);
`ifdef FETCH_RETIRE_COUNT_EN
        chk("retireCount", int'(retireCount), e.retire);
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);

    // reset, start, sequential fetch
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // absolute jump 0x05 -> 0x20
    step(0, 0, 0, 0, 0, 1, 0, 8'h05, 0);
    step(0, 0, 0, 0, 0, 1, 0, 8'h20, 0);
    // relative branch taken / not taken from 0x10
    step(0, 0, 0, 0, 0, 1, 0, 8'h10, 0);
    step(0, 0, 0, 0, 1, 0, 1, 8'hFC, 1);
    step(0, 0, 0, 0, 0, 1, 0, 8'h10, 0);
    step(0, 0, 0, 0, 1, 0, 1, 8'hFC, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // wrap on increment and on relative jump
    step(0, 0, 0, 0, 0, 1, 0, 8'hFF, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 8'hF0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 8'h20, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // halt beats jump at 0x07; stall ignored while halted; restart
    step(0, 0, 0, 0, 0, 1, 0, 8'h07, 0);
    step(0, 0, 0, 1, 0, 1, 0, 8'h30, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1, 0, 8'h30, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // stall two cycles at 0x03 with a pending jump, then release
    step(0, 0, 0, 0, 0, 1, 0, 8'h03, 0);
    step(0, 0, 1, 0, 0, 1, 0, 8'h40, 0);
    step(0, 0, 1, 1, 0, 1, 0, 8'h40, 0);
    step(0, 0, 0, 0, 0, 1, 0, 8'h40, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // start ignored in RUN, reset mid-RUN abandons a redirect
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 8'h55, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 300) == 0, ($urandom % 8) == 0, ($urandom % 5) == 0,
           ($urandom % 24) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0,
           ($urandom % 2) == 0, int'($urandom % 256), ($urandom % 2) == 0);
    end

    @(negedge clk);
    #5;
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
